// File: rtl/mult32_seq.sv
// Sequential 32x32 shift-and-add multiplier with start/busy/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module mult32_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                state_q, state_d;
   logic                  accept;
   logic [2*DATA_W-1:0]   mcand;
   logic [DATA_W-1:0]     mplier;
   logic [2*DATA_W-1:0]   acc;
   logic [5:0]            count;
   logic [DATA_W-1:0]     op_a, op_b;
   logic [2*DATA_W-1:0]   result;

`ifdef MULT_SIGNED_EN
   logic                  neg;

   // The most negative input maps onto itself, which is its correct unsigned magnitude.
   function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
      logic [DATA_W-1:0] m;
      m = x[DATA_W-1] ? DATA_W'(-x) : DATA_W'(x);
      return m;
   endfunction

   function automatic logic [2*DATA_W-1:0] apply_sign(input logic [2*DATA_W-1:0] v,
                                                      input logic n);
      return n ? (~v + 64'd1) : v;
   endfunction

   assign op_a   = magnitude(a);
   assign op_b   = magnitude(b);
   assign result = apply_sign(acc, neg);
`else
   assign op_a   = a;
   assign op_b   = b;
   assign result = acc;
`endif

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = (a == '0 || b == '0) ? DONE : CALC;
            end
         end
         CALC:    if (count == 6'd31) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
`ifdef MULT_SIGNED_EN
         neg     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         // busy also covers the done-pulse cycle, when the FSM is already back in IDLE
         busy    <= (state_d != IDLE) || (state_q == DONE);
         done    <= (state_q == DONE);
         if (accept) begin
            mcand  <= {{DATA_W{1'b0}}, op_a};
            mplier <= op_b;
            acc    <= '0;
            count  <= '0;
`ifdef MULT_SIGNED_EN
            neg    <= a[DATA_W-1] ^ b[DATA_W-1];
`endif
         end else if (state_q == CALC) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 6'd1;
         end
         if (state_q == DONE) begin
            hi <= result[2*DATA_W-1:DATA_W];
            lo <= result[DATA_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_mult32_seq.sv
// Scoreboard bench for mult32_seq: stimulus pushes expected product and latency,
// a monitor pops and compares on every done pulse.
module tb_mult32_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [63:0] prod;
      int          lat;
      int          c0;
      string       name;
   } exp_t;

   exp_t sb[$];

   mult32_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, "_product"}, {hi, lo}, e.prod);
            chk({e.name, "_latency"}, 64'(cyc - e.c0), 64'(e.lat));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge E0.
   task automatic issue(input string name, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [63:0] prod, input int lat);
      exp_t e;
      start = 1'b1;
      a     = ia;
      b     = ib;
      @(negedge clk);
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      b     = 32'hCAFE_F00D;
      e.prod = prod;
      e.lat  = lat;
      e.c0   = cyc;
      e.name = name;
      sb.push_back(e);
      chk({name, "_busy_after_start"}, 64'(busy), 64'd1);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 100);
      if (done !== 1'b1) chk({name, "_done_timeout"}, 64'd0, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] p_ff, p_neg;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi",   64'(hi),   64'd0);
      chk("reset_lo",   64'(lo),   64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 3 x 5, then busy must fall after the done cycle
      issue("mul_3x5", 32'd3, 32'd5, 64'd15, 33);
      wait_done("mul_3x5");
      @(negedge clk);
      chk("busy_after_done", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("hold_hilo", {hi, lo}, 64'd15);

`ifdef MULT_SIGNED_EN
      p_ff  = 64'h0000_0000_0000_0001;
      p_neg = 64'hFFFF_FFFF_FFFF_FFFA;
`else
      p_ff  = 64'hFFFF_FFFE_0000_0001;
      p_neg = 64'h0000_0002_FFFF_FFFA;
`endif
      issue("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, p_ff, 33);
      wait_done("mul_ffxff");
      @(negedge clk);
      issue("mul_m2x3", 32'hFFFF_FFFE, 32'd3, p_neg, 33);
      wait_done("mul_m2x3");
      @(negedge clk);
      issue("mul_8000sq", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
      wait_done("mul_8000sq");
      @(negedge clk);

      // zero fast path followed immediately by a back-to-back start
      issue("mul_zero", 32'd0, 32'h1234_5678, 64'd0, 1);
      wait_done("mul_zero");
      issue("mul_7x6_b2b", 32'd7, 32'd6, 64'd42, 33);
      wait_done("mul_7x6_b2b");
      @(negedge clk);

      // start pulses during CALC must be ignored
      issue("mul_9x9_ign", 32'd9, 32'd9, 64'd81, 33);
      repeat (4) @(negedge clk);
      start = 1'b1; a = 32'd100; b = 32'd100;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      start = 1'b1; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      wait_done("mul_9x9_ign");
      repeat (40) @(negedge clk);
      chk("ign_no_extra_job", 64'(busy), 64'd0);

      // reset asserted mid-CALC: outputs cleared, no done pulse
      issue("mul_9x9_rst", 32'd9, 32'd9, 64'd81, 33);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      sb.delete();
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_idle", 64'(busy), 64'd0);
      issue("mul_4x5_after_rst", 32'd4, 32'd5, 64'd20, 33);
      wait_done("mul_4x5_after_rst");
      repeat (5) @(negedge clk);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult32_seq.md
# mult32_seq

Sequential 32×32 shift-and-add multiplier for the ALU datapath. It feeds the HI/LO result registers with a 64-bit product computed one multiplier bit per cycle. Each cycle it shifts the multiplicand left by one and the multiplier right by one. A start/busy/done handshake lets the control unit stall while it runs.

## Interface
Parameters: none. Width is fixed at 32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request a multiply; sampled only in IDLE.
- a  input  32  multiplicand; captured on the accepted start edge.
- b  input  32  multiplier; captured on the accepted start edge.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse; hi/lo valid from this cycle onward.
- hi  output  32  product[63:32].
- lo  output  32  product[31:0].

## Operation
- Reset values: state = IDLE, busy = 0, done = 0, hi = 0, lo = 0. All internal registers are also 0.
- States and transitions:
  - IDLE → CALC when start = 1.
  - IDLE → DONE when start = 1 and (a == 0 or b == 0). This is the zero fast path.
  - CALC → DONE after 32 iterations.
  - DONE → IDLE unconditionally.
- Capture on the accepted start edge:
  - mcand[63:0] = {32'b0, |a|}.
  - mplier[31:0] = |b|.
  - acc[63:0] = 0.
  - count = 0.
  - Operands are used unmodified in unsigned mode; see Configuration for signed mode.
- Each CALC edge:
  - If mplier[0] = 1: acc = acc + mcand, modulo 2^64. The carry out of bit 63 is discarded; it cannot occur for magnitudes below 2^32.
  - mcand = mcand << 1, zero-filled.
  - mplier = mplier >> 1, zero-filled.
  - count = count + 1, using a 6-bit counter.
  - After the edge where count goes from 31 to 32: move to DONE.
- Entry to DONE: {hi, lo} loads the final product and done = 1.
- hi/lo are held until the next accepted start completes. They are not cleared on start.
- start in CALC or DONE is ignored and is not queued.
- a and b are don't-care except on the accepted start edge.
- rst_n low on any edge, including mid-CALC: return to IDLE, clear all outputs, no done pulse.

## Timing
- Let E0 be the edge that accepts start.
- busy = 1 from E0 through the cycle in which done is high.
- Normal path:
  - CALC edges are E1..E32.
  - done is high for exactly one cycle, after E33.
  - Latency from start to done is 33 cycles.
- Zero fast path: done is high after E1. Latency is 1 cycle; hi = lo = 0.
- Back-to-back operation: the earliest next accepted start is the edge that ends the done cycle, i.e. DONE → IDLE, then start is sampled in IDLE on the following edge.
- Outputs are all registered, with no combinational path from inputs to outputs.

## Configuration
- MULT_SIGNED_EN defined:
  - a and b are two's complement.
  - Capture stores |a| and |b|, plus neg = a[31] ^ b[31].
  - On entry to DONE, the product is negated (two's complement, 64-bit) when neg = 1.
  - Latency is unchanged.
  - |0x80000000| = 0x80000000, treated as an unsigned magnitude.
- MULT_SIGNED_EN undefined:
  - Operands are unsigned and neg logic is absent.
  - Product is the unsigned a × b.

## Test plan
- Reset then a=3, b=5, start: busy rises after E0; done after E33; hi=0x00000000, lo=0x0000000F; busy low after the done cycle.
- Unsigned build, a=b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001. Signed build, same inputs: hi=0x00000000, lo=0x00000001.
- Signed build, a=0xFFFFFFFE (−2), b=3: hi=0xFFFFFFFF, lo=0xFFFFFFFA. Also a=b=0x80000000: hi=0x40000000, lo=0 in both builds.
- a=0, b=0x12345678: done after E1, hi=lo=0. Then a=7, b=6 back-to-back: lo=42 after 33 more cycles.
- start pulsed at E5 and E20 during a 9×9 operation: ignored; a single done after E33 with lo=81.
- rst_n low at E10 of a 9×9 operation: busy=0, hi=lo=0, no done pulse. A new start after release completes normally.
